// File: rtl/id_fetch_ctrl.sv
// ID-stage front end: owns the IF/ID pipeline register, decodes the
// instruction held there, resolves beq/bne/j/jal/jr in ID and steers the
// fetch stage (redirect target, flush, stall). Load-use and branch-operand
// hazards freeze fetch and IF/ID while a bubble is pushed into ID/EX.
module id_fetch_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_if,
  input  logic [31:0]      instr_if,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  input  logic             memread_ex,
  input  logic             regwrite_ex,
  input  logic [4:0]       dest_ex,
  input  logic             memread_mem,
  input  logic [4:0]       dest_mem,
  output logic             Branch,
  output logic             Jump,
  output logic [31:0]      JumpAddr,
  output logic             IFWrite,
  output logic [31:0]      instr_id,
  output logic [31:0]      pc4_id,
  output logic             valid_id,
  output logic             bubble,
  output logic [4:0]       rs_id,
  output logic [4:0]       rt_id,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // imm16 sign-extended and scaled to a byte offset.
  function automatic logic signed [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

  logic [31:0]      instr_id_q, instr_id_d;
  logic [31:0]      pc4_id_q, pc4_id_d;
  logic             valid_id_q, valid_id_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs, rt;
  logic       is_beq, is_bne, is_j, is_jal, is_jr;
  logic       uses_rs, uses_rt;
  logic       cmp_uses_rt;

  logic       load_use, branch_dep, stall;
  logic       ex_hit_cmp, mem_hit_cmp;
  logic       take_branch, take_jump, redirect;
  logic [31:0] jump_addr;

  // Field extraction and instruction-class decode of the IF/ID word.
  always_comb begin
    opcode  = instr_id_q[31:26];
    funct   = instr_id_q[5:0];
    rs      = instr_id_q[25:21];
    rt      = instr_id_q[20:16];
    is_beq  = (opcode == OP_BEQ);
    is_bne  = (opcode == OP_BNE);
    is_j    = (opcode == OP_J);
    is_jal  = (opcode == OP_JAL);
    is_jr   = (opcode == OP_RTYPE) && (funct == FN_JR);
    uses_rs = !(is_j || is_jal);
    uses_rt = (opcode == OP_RTYPE) || is_beq || is_bne || (opcode == OP_SW);
    // jr compares nothing against rt; only rs is its operand.
    cmp_uses_rt = is_beq || is_bne;
  end

  // Hazard detection; register 0 is hard-wired and never creates a dependency.
  always_comb begin
    load_use = memread_ex && (dest_ex != 5'd0) &&
               ((uses_rs && (dest_ex == rs)) || (uses_rt && (dest_ex == rt)));
    ex_hit_cmp  = (dest_ex != 5'd0) &&
                  ((dest_ex == rs) || (cmp_uses_rt && (dest_ex == rt)));
    mem_hit_cmp = (dest_mem != 5'd0) &&
                  ((dest_mem == rs) || (cmp_uses_rt && (dest_mem == rt)));
    branch_dep = (is_beq || is_bne || is_jr) &&
                 ((regwrite_ex && ex_hit_cmp) || (memread_mem && mem_hit_cmp));
    stall = valid_id_q && (load_use || branch_dep);
  end

  // Branch/jump resolution and redirect target; a stalled control transfer
  // waits until its operands are forwarded, so redirect never overlaps stall.
  always_comb begin
    take_branch = valid_id_q && !stall &&
                  ((is_beq && (rs_data == rt_data)) || (is_bne && (rs_data != rt_data)));
    take_jump   = valid_id_q && !stall && (is_j || is_jal || is_jr);
    redirect    = take_branch || take_jump;
    jump_addr   = 32'd0;
    if (take_branch) begin
      jump_addr = pc4_id_q + $unsigned(branch_offset(instr_id_q[15:0]));
    end else if (take_jump && is_jr) begin
      jump_addr = rs_data;
    end else if (take_jump) begin
      jump_addr = {pc4_id_q[31:28], instr_id_q[25:0], 2'b00};
    end
  end

  // Next IF/ID contents and performance-counter updates.
  always_comb begin
    instr_id_d  = instr_id_q;
    pc4_id_d    = pc4_id_q;
    valid_id_d  = valid_id_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else if (redirect) begin
      // The fall-through word fetched this cycle is squashed into a NOP.
      instr_id_d  = 32'd0;
      valid_id_d  = 1'b0;
      pc4_id_d    = pc_if + 32'd4;
      flush_cnt_d = sat_inc(flush_cnt_q);
    end else begin
      instr_id_d = instr_if;
      valid_id_d = 1'b1;
      pc4_id_d   = pc_if + 32'd4;
    end
  end

  // IF/ID register and counters; reset wins over stall and redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_id_q  <= 32'd0;
      pc4_id_q    <= 32'd0;
      valid_id_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      instr_id_q  <= instr_id_d;
      pc4_id_q    <= pc4_id_d;
      valid_id_q  <= valid_id_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Branch    = take_branch;
  assign Jump      = take_jump;
  assign JumpAddr  = jump_addr;
  assign IFWrite   = !stall;
  assign bubble    = stall || !valid_id_q;
  assign instr_id  = instr_id_q;
  assign pc4_id    = pc4_id_q;
  assign valid_id  = valid_id_q;
  assign rs_id     = rs;
  assign rt_id     = rt;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_fetch_ctrl.sv
// Bench for id_fetch_ctrl: directed scenarios for redirects and hazards,
// then randomized traffic compared against a behavioural pipeline model.
module tb_id_fetch_ctrl;

  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic [31:0]      pc_if, instr_if, rs_data, rt_data;
  logic             memread_ex, regwrite_ex, memread_mem;
  logic [4:0]       dest_ex, dest_mem;
  logic             Branch, Jump, IFWrite, valid_id, bubble;
  logic [31:0]      JumpAddr, instr_id, pc4_id;
  logic [4:0]       rs_id, rt_id;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  id_fetch_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .pc_if(pc_if), .instr_if(instr_if),
    .rs_data(rs_data), .rt_data(rt_data),
    .memread_ex(memread_ex), .regwrite_ex(regwrite_ex), .dest_ex(dest_ex),
    .memread_mem(memread_mem), .dest_mem(dest_mem),
    .Branch(Branch), .Jump(Jump), .JumpAddr(JumpAddr), .IFWrite(IFWrite),
    .instr_id(instr_id), .pc4_id(pc4_id), .valid_id(valid_id), .bubble(bubble),
    .rs_id(rs_id), .rt_id(rt_id), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural model: what sits in the IF/ID slot and the counter totals.
  logic [31:0] m_instr, m_pc4;
  bit          m_valid;
  int          m_stall, m_flush;

  function automatic logic [31:0] r_type(int rs, int rt, int rd, int fn);
    return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(fn);
  endfunction

  function automatic logic [31:0] i_type(int op, int rs, int rt, logic [15:0] imm);
    return (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
  endfunction

  // One clock: optionally compare every output with the model, then advance
  // the model across the edge. Inputs are held by the caller for the cycle.
  task automatic cyc(input bit do_check);
    int op, fn, rs, rt, off;
    bit reads_rs, reads_rt, ctrl_xfer, lu, dep, st, br, jp;
    logic [31:0] tgt;
    @(negedge clk);
    op = int'(m_instr >> 26);
    fn = int'(m_instr & 32'h3F);
    rs = int'((m_instr >> 21) & 32'h1F);
    rt = int'((m_instr >> 16) & 32'h1F);
    reads_rs  = !(op == 2 || op == 3);
    reads_rt  = (op == 0 || op == 4 || op == 5 || op == 43);
    ctrl_xfer = (op == 4 || op == 5 || (op == 0 && fn == 8));
    lu = memread_ex && dest_ex != 0 &&
         ((reads_rs && int'(dest_ex) == rs) || (reads_rt && int'(dest_ex) == rt));
    dep = 0;
    if (ctrl_xfer) begin
      if (regwrite_ex && dest_ex != 0 &&
          (int'(dest_ex) == rs || (op != 0 && int'(dest_ex) == rt))) dep = 1;
      if (memread_mem && dest_mem != 0 &&
          (int'(dest_mem) == rs || (op != 0 && int'(dest_mem) == rt))) dep = 1;
    end
    st = m_valid && (lu || dep);
    br = m_valid && !st && ((op == 4 && rs_data == rt_data) || (op == 5 && rs_data != rt_data));
    jp = m_valid && !st && (op == 2 || op == 3 || (op == 0 && fn == 8));
    tgt = 0;
    if (br) begin
      off = int'($signed(m_instr[15:0]));
      tgt = m_pc4 + 32'(off * 4);
    end else if (jp && op == 0) begin
      tgt = rs_data;
    end else if (jp) begin
      tgt = (m_pc4 & 32'hF000_0000) + (m_instr & 32'h03FF_FFFF) * 4;
    end
    if (do_check) begin
      check("Branch",    64'(Branch),    64'(br));
      check("Jump",      64'(Jump),      64'(jp));
      check("JumpAddr",  64'(JumpAddr),  64'(tgt));
      check("IFWrite",   64'(IFWrite),   64'(!st));
      check("bubble",    64'(bubble),    64'(st || !m_valid));
      check("instr_id",  64'(instr_id),  64'(m_instr));
      check("pc4_id",    64'(pc4_id),    64'(m_pc4));
      check("valid_id",  64'(valid_id),  64'(m_valid));
      check("rs_id",     64'(rs_id),     64'(rs));
      check("rt_id",     64'(rt_id),     64'(rt));
      check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
    end
    @(posedge clk);
    if (reset) begin
      m_instr = 0; m_pc4 = 0; m_valid = 0; m_stall = 0; m_flush = 0;
    end else if (st) begin
      if (m_stall < CMAX) m_stall++;
    end else if (br || jp) begin
      m_instr = 0; m_valid = 0; m_pc4 = pc_if + 4;
      if (m_flush < CMAX) m_flush++;
    end else begin
      m_instr = instr_if; m_valid = 1; m_pc4 = pc_if + 4;
    end
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [31:0] rand_instr();
    int rs, rt, rd;
    logic [15:0] imm;
    rs  = $urandom_range(0, 7);
    rt  = $urandom_range(0, 7);
    rd  = $urandom_range(0, 7);
    imm = 16'($urandom);
    case ($urandom_range(0, 8))
      0: return r_type(rs, rt, rd, 32);
      1: return r_type(rs, 0, 0, 8);
      2: return i_type(4, rs, rt, imm);
      3: return i_type(5, rs, rt, imm);
      4: return (32'd2 << 26) | ($urandom & 32'h03FF_FFFF);
      5: return (32'd3 << 26) | ($urandom & 32'h03FF_FFFF);
      6: return i_type(35, rs, rt, imm);
      7: return i_type(43, rs, rt, imm);
      default: return i_type(8, rs, rt, imm);
    endcase
  endfunction

  initial begin
    logic [31:0] add_a, add_b;
    m_instr = 0; m_pc4 = 0; m_valid = 0; m_stall = 0; m_flush = 0;
    add_a = r_type(1, 2, 3, 32);
    add_b = r_type(4, 5, 3, 32);
    reset = 1; pc_if = 0; instr_if = add_a; rs_data = 0; rt_data = 0;
    memread_ex = 0; regwrite_ex = 0; dest_ex = 0; memread_mem = 0; dest_mem = 0;

    // Reset behaviour.
    cyc(0);
    cyc(1);
    settle();
    check("rst_IFWrite", 64'(IFWrite), 64'd1);
    check("rst_bubble",  64'(bubble),  64'd1);
    check("rst_Branch",  64'(Branch),  64'd0);
    check("rst_Jump",    64'(Jump),    64'd0);
    check("rst_instr",   64'(instr_id), 64'd0);
    reset = 0;
    cyc(1);
    check("post_rst_valid", 64'(valid_id), 64'd1);
    check("post_rst_pc4",   64'(pc4_id),   64'd4);

    // Taken beq at 0x10.
    pc_if = 32'h10; instr_if = i_type(4, 1, 2, 16'h0003); rs_data = 5; rt_data = 5;
    cyc(1);
    pc_if = 32'h14; instr_if = add_a;
    settle();
    check("beq_Branch", 64'(Branch),   64'd1);
    check("beq_target", 64'(JumpAddr), 64'h20);
    cyc(1);
    check("beq_squash_instr", 64'(instr_id),  64'd0);
    check("beq_squash_valid", 64'(valid_id),  64'd0);
    check("beq_flush_cnt",    64'(flush_cnt), 64'd1);

    // Backward bne.
    pc_if = 32'h20; instr_if = i_type(5, 1, 2, 16'hFFFF); rs_data = 1; rt_data = 2;
    cyc(1);
    settle();
    check("bne_pc4",    64'(pc4_id),   64'h24);
    check("bne_Branch", 64'(Branch),   64'd1);
    check("bne_target", 64'(JumpAddr), 64'h20);
    cyc(1);

    // jal across a high PC region.
    pc_if = 32'h8000_0004; instr_if = (32'd3 << 26) | 32'h40;
    cyc(1);
    settle();
    check("jal_Jump",   64'(Jump),     64'd1);
    check("jal_target", 64'(JumpAddr), 64'h8000_0100);
    cyc(1);

    // Load-use stall on rt.
    pc_if = 32'h100; instr_if = add_b;
    cyc(1);
    memread_ex = 1; dest_ex = 5; pc_if = 32'h104; instr_if = i_type(4, 7, 8, 16'h0004);
    settle();
    check("lu_IFWrite", 64'(IFWrite), 64'd0);
    check("lu_bubble",  64'(bubble),  64'd1);
    cyc(1);
    check("lu_hold_instr", 64'(instr_id),  64'(add_b));
    check("lu_hold_pc4",   64'(pc4_id),    64'h104);
    check("lu_stall_cnt",  64'(stall_cnt), 64'd1);
    memread_ex = 0; dest_ex = 0;
    settle();
    check("lu_release", 64'(IFWrite), 64'd1);
    cyc(1);

    // beq $7 behind lw $7: EX match then MEM match, then resolves.
    memread_ex = 1; regwrite_ex = 1; dest_ex = 7; rs_data = 9; rt_data = 9;
    settle();
    check("ld_br_s1_Branch",  64'(Branch),  64'd0);
    check("ld_br_s1_IFWrite", 64'(IFWrite), 64'd0);
    cyc(1);
    memread_ex = 0; regwrite_ex = 0; dest_ex = 0; memread_mem = 1; dest_mem = 7;
    settle();
    check("ld_br_s2_Branch",  64'(Branch),  64'd0);
    check("ld_br_s2_IFWrite", 64'(IFWrite), 64'd0);
    cyc(1);
    memread_mem = 0; dest_mem = 0;
    settle();
    check("ld_br_Branch", 64'(Branch),    64'd1);
    check("ld_br_target", 64'(JumpAddr),  64'h118);
    check("ld_br_stalls", 64'(stall_cnt), 64'd3);
    cyc(1);

    // Continuous stall until the counter saturates, then reset mid-stall.
    pc_if = 32'h118; instr_if = add_b;
    cyc(1);
    memread_ex = 1; dest_ex = 4;
    for (int i = 0; i < CMAX + 8; i++) cyc(0);
    settle();
    check("sat_stall_cnt", 64'(stall_cnt), 64'hFFFF);
    check("sat_IFWrite",   64'(IFWrite),   64'd0);
    reset = 1;
    cyc(1);
    reset = 0; memread_ex = 0; dest_ex = 0;
    settle();
    check("rst_mid_stall_cnt",   64'(stall_cnt), 64'd0);
    check("rst_mid_stall_valid", 64'(valid_id),  64'd0);
    check("rst_mid_stall_flush", 64'(flush_cnt), 64'd0);
    cyc(1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 63) == 0);
      pc_if       = $urandom & 32'hFFFF_FFFC;
      instr_if    = rand_instr();
      rs_data     = $urandom_range(0, 3);
      rt_data     = ($urandom_range(0, 1) == 1) ? rs_data : 32'($urandom);
      memread_ex  = ($urandom_range(0, 3) == 0);
      regwrite_ex = memread_ex || ($urandom_range(0, 1) == 1);
      dest_ex     = 5'($urandom_range(0, 7));
      memread_mem = ($urandom_range(0, 3) == 0);
      dest_mem    = 5'($urandom_range(0, 7));
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
